iterative_shifter: RTL
======================

# iterative_shifter

Multi-cycle, parametrised shift unit for the MIPS datapath, replacing the fixed shift-by-2 block. It performs logical-left, logical-right, arithmetic-right and (optionally) rotate-right on a WIDTH-bit operand by a run-time amount. It advances STEP bit positions per clock under a start/done handshake. It sits beside the ALU and serves SLL/SRL/SRA/SLLV/SRLV/SRAV, holding its result until the next operation.

## Interface
- WIDTH, 32, operand/result width; power of two, at least 8.
- STEP, 1, maximum bit positions shifted per cycle; power of two, 1 to WIDTH.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  in  1  request; accepted only when busy=0.
- op  in  2  operation code: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- din  in  WIDTH  operand; sampled with start.
- shamt  in  SHAMT_W  shift amount; sampled with start.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse; result valid.
- dout  out  WIDTH  result; held from the done pulse until the next accepted start.

## Operation
- Reset: state IDLE; busy=0, done=0, dout=0. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE, DONE: start=1 loads din into the working register, latches op, and sets remaining=shamt.
    - Next state is SHIFT if shamt≠0, else DONE.
    - In DONE with start=0, the next state is IDLE.
  - SHIFT: each cycle shifts the working register by s=min(STEP, remaining) and sets remaining-=s. When remaining reaches 0, the next state is DONE.
- Fill rules:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: replicate the original din[WIDTH-1].
  - ROTR: bits shifted out of the LSB re-enter at the MSB.
- Output signals:
  - busy=1 exactly while in SHIFT.
  - done=1 exactly while in DONE.
  - dout updates to the working register on entry to DONE. It is unchanged otherwise.
- start while busy=1 is ignored. It is not queued.
- start in DONE is accepted (back-to-back operation). done still pulses for the completing result in that cycle.
- shamt ≥ WIDTH cannot occur, because SHAMT_W bounds it to WIDTH-1.

## Timing
- Let k = ceil(shamt/STEP). Call the cycle in which start is sampled cycle 0.
- done is high in cycle k+1:
  - shamt=0: cycle 1.
  - STEP=1: cycle shamt+1.
  - Maximum latency: ceil((WIDTH-1)/STEP)+1.
- busy is high in cycles 1..k and low in cycle k+1.
- Throughput: one operation per k+1 cycles with back-to-back start.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- SHIFTER_ROTATE_EN defined: op=11 performs ROTR per the rules above.
- SHIFTER_ROTATE_EN undefined:
  - op=11 is treated as an identity operation: dout=din.
  - done goes high in cycle 1 regardless of shamt.
  - No rotate datapath is built.

## Structure
- Package shifter_pkg:
  - op encoding constants OP_SLL, OP_SRL, OP_SRA, OP_ROTR.
  - state enum IDLE/SHIFT/DONE.
- Sub-module shift_step: combinational single-step shifter.
  - Inputs: value, op, fill bit, amount 0..STEP.
  - Output: the shifted value.
- The top level holds the FSM, working register, remaining counter and dout register.

## Test plan
- WIDTH=32, STEP=1, SLL din=65 shamt=2 -> dout=260, done in cycle 3, busy cycles 1–2.
- SRA din=0x8000_0000 shamt=4 -> dout=0xF800_0000; SRL with the same input -> 0x0800_0000.
- SRL din=234 shamt=0 -> dout=234, done in cycle 1, busy never high.
- STEP=4, SRL din=0xFFFF_FFFF shamt=31 -> dout=0x0000_0001, done in cycle 9. Then issue an immediate start in the DONE cycle (SLL 1 by 1) -> dout=2 two cycles later.
- ROTR din=0x0000_00EA shamt=8 -> dout=0xEA00_0000 with the macro defined, dout=0x0000_00EA in cycle 1 without it.
- Reset and ignored start:
  - Assert rst_n=0 during SHIFT -> next cycle busy=0, done=0, dout=0, with no later done pulse.
  - start pulsed while busy -> ignored, and the original result completes unchanged.

Source files
------------

// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the iterative shifter:
//   OP_SLL / OP_SRL / OP_SRA / OP_ROTR : operation encodings on the op input
//   state_e                            : controller states IDLE / SHIFT / DONE
// No ports (package).
// ---------------------------------------------------------------------------
package shifter_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-step shifter used by iterative_shifter for one
// iteration of a multi-cycle shift.
// Configuration macro: SHIFTER_ROTATE_EN (builds the rotate-right path;
// without it op=11 passes the value through unchanged).
// Ports:
//   i_value  in  WIDTH    value to shift
//   i_op     in  2        operation (OP_SLL/OP_SRL/OP_SRA/OP_ROTR)
//   i_fill   in  1        sign bit replicated into the MSBs for SRA
//   i_amt    in  SHAMT_W  bit positions to shift this step
//   o_value  out WIDTH    shifted value
// ---------------------------------------------------------------------------
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_value,
  input  logic [1:0]         i_op,
  input  logic               i_fill,
  input  logic [SHAMT_W-1:0] i_amt,
  output logic [WIDTH-1:0]   o_value
);

  // Right-type shifts share one datapath: the operand is extended with an
  // upper half (zeros, sign copies, or the operand itself for rotate) and the
  // low WIDTH bits of the shifted double-width word are the result.
  // The step amount never exceeds WIDTH-1, so SHAMT_W bits always suffice.
  logic [WIDTH-1:0] w_upper;

  always_comb begin
    w_upper = '0;
    case (i_op)
      OP_SRA:  w_upper = {WIDTH{i_fill}};
`ifdef SHIFTER_ROTATE_EN
      OP_ROTR: w_upper = i_value;
`endif
      default: w_upper = '0;
    endcase
  end

  always_comb begin
    o_value = i_value;
    case (i_op)
      OP_SLL:  o_value = i_value << i_amt;
      OP_SRL,
      OP_SRA:  o_value = WIDTH'({w_upper, i_value} >> i_amt);
`ifdef SHIFTER_ROTATE_EN
      OP_ROTR: o_value = WIDTH'({w_upper, i_value} >> i_amt);
`endif
      default: o_value = i_value;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// ---------------------------------------------------------------------------
// iterative_shifter
// Multi-cycle shift unit (SLL/SRL/SRA and optional ROTR) advancing up to STEP
// bit positions per clock under a start/done handshake. The result is held on
// dout from the done pulse until the next accepted start.
// Configuration macro: SHIFTER_ROTATE_EN
//   defined   : op=11 rotates right by shamt
//   undefined : op=11 is an identity op (dout=din, done in cycle 1)
// Ports:
//   clk    in  1        rising-edge clock
//   rst_n  in  1        synchronous active-low reset
//   start  in  1        request, accepted in IDLE or DONE
//   op     in  2        00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   din    in  WIDTH    operand, sampled with start
//   shamt  in  SHAMT_W  shift amount, sampled with start
//   busy   out 1        high while in SHIFT
//   done   out 1        high for the single DONE cycle
//   dout   out WIDTH    result register
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for start
// SHIFT | shifting working register, remaining > 0
// DONE  | result on dout, done pulse; start accepted back-to-back
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int STEP    = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  // remaining is at most WIDTH-1, so a STEP of WIDTH behaves like WIDTH-1
  // and the per-step cap always fits in SHAMT_W bits.
  localparam int                 STEP_CAP = (STEP < WIDTH) ? STEP : WIDTH - 1;
  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP_CAP);

  state_e               r_state;
  logic [WIDTH-1:0]     r_work;
  logic [1:0]           r_op;
  logic                 r_fill;
  logic [SHAMT_W-1:0]   r_rem;
  logic [WIDTH-1:0]     r_dout;

  logic [SHAMT_W-1:0]   w_amt;
  logic [WIDTH-1:0]     w_step;
  logic [SHAMT_W-1:0]   w_load_rem;
  logic                 w_last;

  always_comb begin
    w_amt  = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
    w_last = (r_rem == w_amt);
  end

`ifdef SHIFTER_ROTATE_EN
  assign w_load_rem = shamt;
`else
  // Without the rotate path op=11 completes immediately as a pass-through.
  assign w_load_rem = (op == OP_ROTR) ? '0 : shamt;
`endif

  shift_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift_step (
    .i_value (r_work),
    .i_op    (r_op),
    .i_fill  (r_fill),
    .i_amt   (w_amt),
    .o_value (w_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_op    <= OP_SLL;
      r_fill  <= 1'b0;
      r_rem   <= '0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_work <= din;
            r_op   <= op;
            r_fill <= din[WIDTH-1];
            r_rem  <= w_load_rem;
            if (w_load_rem != '0) begin
              r_state <= SHIFT;
            end else begin
              r_state <= DONE;
              r_dout  <= din;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_work <= w_step;
          r_rem  <= r_rem - w_amt;
          if (w_last) begin
            r_state <= DONE;
            r_dout  <= w_step;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign dout = r_dout;

endmodule
